// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle binary adder. It adds BITS_PER_CYCLE bits per clock and carries
// the carry from one chunk to the next, so a WIDTH-bit add takes
// N = WIDTH/BITS_PER_CYCLE processing cycles. Operands arrive over a
// valid/ready handshake, and results leave over a second one. Only one
// operation is in flight at a time.
//
// Parameters
//   WIDTH           operand and sum width in bits (>= 2)
//   BITS_PER_CYCLE  bits added per clock; must divide WIDTH exactly
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand transfer request
//   in_ready   block can accept operands (IDLE only)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in
//   sub        (SERIAL_ADDER_SUB_EN only) 1 = compute a - b, cin ignored
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   sum        registered result, a + b + cin mod 2^WIDTH
//   cout       registered carry out of the MSB (no-borrow when subtracting)
//   overflow   registered signed overflow (carry into MSB ^ carry out of MSB)
//
// Build option
//   SERIAL_ADDER_SUB_EN  when defined, adds the sub port and subtract mode.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int BPC   = BITS_PER_CYCLE;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             msb_cin;
    logic [CNT_W-1:0] cnt;
    logic             fin;

    logic [WIDTH-1:0]         b_load;
    logic                     carry_load;
    logic [BPC:0]             chunk;
    logic                     chunk_msb_cin;
    logic [WIDTH+BPC-1:0]     sum_cat;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand conditioning at load time: subtraction is a + ~b + 1.
    always_comb begin
        b_load     = b;
        carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load     = ~b;
            carry_load = 1'b1;
        end
`endif
    end

    // One chunk of the ripple add. The carry into the chunk's top bit is
    // recovered from sum ^ a ^ b of that bit, so it works for any chunk width.
    // sum_cat appends the new chunk above the partial sum; taking its upper
    // WIDTH bits shifts the sum register right by one chunk, even when a chunk
    // spans the whole word.
    always_comb begin
        chunk         = {1'b0, a_sh[BPC-1:0]} + {1'b0, b_sh[BPC-1:0]}
                      + {{BPC{1'b0}}, carry};
        chunk_msb_cin = chunk[BPC-1] ^ a_sh[BPC-1] ^ b_sh[BPC-1];
        sum_cat       = {chunk[BPC-1:0], sum_sh};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            msb_cin  <= 1'b0;
            cnt      <= '0;
            fin      <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        carry  <= carry_load;
                        sum_sh <= '0;
                        cnt    <= '0;
                        fin    <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (fin) begin
                        // All chunks are done. Publish the result as DONE is entered.
                        sum      <= sum_sh;
                        cout     <= carry;
                        overflow <= carry ^ msb_cin;
                        state    <= DONE;
                    end else begin
                        a_sh   <= a_sh >> BPC;
                        b_sh   <= b_sh >> BPC;
                        sum_sh <= sum_cat[WIDTH+BPC-1:BPC];
                        carry  <= chunk[BPC];
                        if (cnt == LAST_CHUNK) begin
                            fin     <= 1'b1;
                            msb_cin <= chunk_msb_cin;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8, e4;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Signals for the BITS_PER_CYCLE=1 instance.
    logic       iv8 = 1'b0, ir8, c8 = 1'b0, sub8 = 1'b0, ov8, or8 = 1'b1, co8, of8;
    logic [7:0] a8 = '0, b8 = '0, s8;
    // Signals for the BITS_PER_CYCLE=4 instance.
    logic       iv4 = 1'b0, ir4, c4 = 1'b0, sub4 = 1'b0, ov4, or4 = 1'b1, co4, of4;
    logic [7:0] a4 = '0, b4 = '0, s4;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(c8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .overflow(of8)
    );

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(c4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4),
`endif
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .overflow(of4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL u8 unexpected result: got %0h, expected none", s8);
            end else begin
                e8 = q8.pop_front();
                chk("u8 sum", s8, e8.s);
                chk("u8 cout", co8, e8.c);
                chk("u8 overflow", of8, e8.o);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL u4 unexpected result: got %0h, expected none", s4);
            end else begin
                e4 = q4.pop_front();
                chk("u4 sum", s4, e4.s);
                chk("u4 cout", co4, e4.c);
                chk("u4 overflow", of4, e4.o);
            end
        end
    end

    // Called #1 after a rising edge with u8 idle.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s_in, input logic [7:0] es, input logic ec,
                        input logic eo, input int bp_cycles);
        int lat;
        a8 = a; b8 = b; c8 = c; sub8 = s_in; iv8 = 1'b1;
        if (bp_cycles > 0) or8 = 1'b0;
        q8.push_back({es, ec, eo});
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("u8 latency", lat, 9);
        if (bp_cycles > 0) begin
            for (int i = 0; i < bp_cycles; i++) begin
                a8 = 8'hAA; b8 = 8'h55; iv8 = 1'b1;
                @(posedge clk); #1;
                chk("bp out_valid held", ov8, 1);
                chk("bp sum held", s8, es);
                chk("bp cout held", co8, ec);
                chk("bp in_ready low", ir8, 0);
            end
            iv8 = 1'b0;
            or8 = 1'b1;
        end
        @(posedge clk); #1;
        chk("u8 in_ready after take", ir8, 1);
        chk("u8 out_valid after take", ov8, 0);
    endtask

    task automatic run4(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        a4 = a; b4 = b; c4 = c; iv4 = 1'b1;
        q4.push_back({es, ec, eo});
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("u4 latency", lat, 3);
        @(posedge clk); #1;
        chk("u4 in_ready after take", ir4, 1);
    endtask

    initial begin
        // Reset values, with in_valid asserted while reset is held.
        #2;
        chk("rst in_ready", ir8, 1);
        chk("rst out_valid", ov8, 0);
        chk("rst sum", s8, 0);
        chk("rst cout", co8, 0);
        chk("rst overflow", of8, 0);
        a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1;
        repeat (2) @(posedge clk);
        #1 iv8 = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst in_ready", ir8, 1);
        chk("post-rst out_valid", ov8, 0);

        run8(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        run8(8'h3C, 8'h0A, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 5);

        // Abort mid-run: no result may appear and outputs clear at once.
        a8 = 8'h55; b8 = 8'h66; c8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort out_valid", ov8, 0);
        chk("abort sum cleared", s8, 0);
        chk("abort in_ready", ir8, 1);
        #2 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort no late out_valid", ov8, 0);
        run8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
        run8(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
`endif

        // Four bits per cycle: carry must cross the nibble boundary.
        run4(8'h9C, 8'h6B, 1'b1, 8'h08, 1'b1, 1'b0);
        run4(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run4(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run4(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("u8 scoreboard drained", q8.size(), 0);
        chk("u4 scoreboard drained", q4.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
